// File: rtl/ecc_30_wr_enc_pkg.sv
// ecc30_pkg: shared H-matrix and codeword layout for the 30-bit
// SEC-DED encoder (write side) and checker (read side).
package ecc30_pkg;

  localparam int ECC30_DATA_WIDTH   = 30;
  localparam int ECC30_PARITY_WIDTH = 7;
  localparam int ECC30_CW_WIDTH     = 37;

  localparam logic [29:0] P0_MASK = 30'h16AA_AD5B;
  localparam logic [29:0] P1_MASK = 30'h1B33_366D;
  localparam logic [29:0] P2_MASK = 30'h23C3_C78E;
  localparam logic [29:0] P3_MASK = 30'h03FC_07F0;
  localparam logic [29:0] P4_MASK = 30'h03FF_F800;
  localparam logic [29:0] P5_MASK = 30'h3C00_0000;
  localparam logic [29:0] P6_MASK = 30'h2DA6_5CB7;

  localparam logic [6:0][29:0] PMASK = {
    P6_MASK, P5_MASK, P4_MASK, P3_MASK,
    P2_MASK, P1_MASK, P0_MASK
  };

  typedef struct packed {
    logic [6:0]  parity;
    logic [29:0] data;
  } codeword_t;

  function automatic logic [6:0] calc_parity(
    input logic [29:0] d
  );
    logic [6:0] p;
    p = '0;
    for (int k = 0; k < 7; k++) begin
      p[k] = ^(d & PMASK[k]);
    end
    return p;
  endfunction

endpackage

// File: rtl/ecc_30_wr_enc_if.sv
// ecc_30_wr_enc_if: upstream/downstream handshake bundle
// plus error-injection controls for the 30-bit encoder.
interface ecc_30_wr_enc_if;
  import ecc30_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [ECC30_DATA_WIDTH-1:0]   in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [ECC30_DATA_WIDTH-1:0]   out_data;
  logic [ECC30_PARITY_WIDTH-1:0] out_parity;
  logic                          inj_en;
  logic                          inj_dbit;
  logic [5:0]                    inj_idx;

  modport slave (
    input  in_valid, in_data, out_ready,
    input  inj_en, inj_dbit, inj_idx,
    output in_ready, out_valid,
    output out_data, out_parity
  );

  modport master (
    output in_valid, in_data, out_ready,
    output inj_en, inj_dbit, inj_idx,
    input  in_ready, out_valid,
    input  out_data, out_parity
  );

endinterface

// File: rtl/ecc_30_enc_core.sv
// ecc_30_enc_core: combinational 30-bit data to 7 check bits,
// shared between the write encoder and the read checker.
module ecc_30_enc_core
  import ecc30_pkg::*;
(
  input  logic [ECC30_DATA_WIDTH-1:0]   data,
  output logic [ECC30_PARITY_WIDTH-1:0] parity
);

  // each check bit is the XOR of its masked data bits
  always_comb begin
    parity = calc_parity(data);
  end

endmodule

// File: rtl/ecc_30_wr_enc.sv
// ecc_30_wr_enc: 30-bit SEC-DED write encoder, 2-entry skid buffer.
// Optional error injection when ECC_ERR_INJ_EN is defined.
module ecc_30_wr_enc #(
  parameter int DATA_WIDTH   = 30,
  parameter int PARITY_WIDTH = 7,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ecc_30_wr_enc_if.slave       bus,
  output logic [CNT_WIDTH-1:0] enc_cnt
);
  import ecc30_pkg::*;

  if (DATA_WIDTH != ECC30_DATA_WIDTH) begin : g_bad_dw
    $error("ecc_30_wr_enc: DATA_WIDTH must be 30");
  end
  if (PARITY_WIDTH != ECC30_PARITY_WIDTH) begin : g_bad_pw
    $error("ecc_30_wr_enc: PARITY_WIDTH must be 7");
  end

  codeword_t                     head;
  codeword_t                     skid;
  codeword_t                     in_cw;
  logic [1:0]                    occ;
  logic [ECC30_PARITY_WIDTH-1:0] enc_par;
  logic                          in_fire;
  logic                          out_fire;

  ecc_30_enc_core u_core (
    .data   (bus.in_data),
    .parity (enc_par)
  );

  assign bus.in_ready   = (occ < 2'd2);
  assign bus.out_valid  = (occ != 2'd0);
  assign bus.out_data   = head.data;
  assign bus.out_parity = head.parity;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

`ifdef ECC_ERR_INJ_EN
  logic [ECC30_CW_WIDTH-1:0] inj_mask;
  logic [5:0]                inj_idx2;

  assign inj_idx2 = (bus.inj_idx == 6'd36) ? 6'd0
                  : bus.inj_idx + 6'd1;

  // one or two codeword bits to invert on this word
  always_comb begin
    inj_mask = '0;
    if (bus.inj_en && (bus.inj_idx <= 6'd36)) begin
      inj_mask[bus.inj_idx] = 1'b1;
      if (bus.inj_dbit) begin
        inj_mask[inj_idx2] = 1'b1;
      end
    end
  end

  assign in_cw = {enc_par, bus.in_data} ^ inj_mask;
`else
  logic unused_inj;

  assign unused_inj = ^{bus.inj_en, bus.inj_dbit, bus.inj_idx};
  assign in_cw      = {enc_par, bus.in_data};
`endif

  // head/skid storage and occupancy; in-order, no change under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= 2'd0;
      head <= '0;
      skid <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10: begin
          if (occ == 2'd0) head <= in_cw;
          else             skid <= in_cw;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= skid;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          head <= in_cw;
        end
        default: begin
        end
      endcase
    end
  end

  // saturating count of words taken downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt <= '0;
    end else if (out_fire && (enc_cnt != {CNT_WIDTH{1'b1}})) begin
      enc_cnt <= enc_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ecc_30_wr_enc.sv
// tb_ecc_30_wr_enc: randomized bench for ecc_30_wr_enc against a
// list-based parity model and a depth-2 FIFO queue model.
module tb_ecc_30_wr_enc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ecc_30_wr_enc_if bus ();
  ecc_30_wr_enc_if bus4 ();
  logic [15:0] enc_cnt;
  logic [3:0]  enc_cnt4;

  ecc_30_wr_enc #(.CNT_WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .enc_cnt (enc_cnt)
  );

  ecc_30_wr_enc #(.CNT_WIDTH(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus4),
    .enc_cnt (enc_cnt4)
  );

  int unsigned tests;
  int unsigned fails;

  localparam int L0 [17] = '{0, 1, 3, 4, 6, 8, 10, 11, 13,
                             15, 17, 19, 21, 23, 25, 26, 28};
  localparam int L1 [17] = '{0, 2, 3, 5, 6, 9, 10, 12, 13,
                             16, 17, 20, 21, 24, 25, 27, 28};
  localparam int L2 [16] = '{1, 2, 3, 7, 8, 9, 10, 14, 15,
                             16, 17, 22, 23, 24, 25, 29};
  localparam int L6 [18] = '{0, 1, 2, 4, 5, 7, 10, 11, 12,
                             14, 17, 18, 21, 23, 24, 26, 27, 29};

  logic [36:0] mq[$];
  int unsigned mcnt;

  function automatic logic [6:0] ref_parity(logic [29:0] d);
    logic [6:0] p;
    p = '0;
    foreach (L0[i]) p[0] ^= d[L0[i]];
    foreach (L1[i]) p[1] ^= d[L1[i]];
    foreach (L2[i]) p[2] ^= d[L2[i]];
    for (int b = 4; b <= 10; b++) p[3] ^= d[b];
    for (int b = 18; b <= 25; b++) p[3] ^= d[b];
    for (int b = 11; b <= 25; b++) p[4] ^= d[b];
    for (int b = 26; b <= 29; b++) p[5] ^= d[b];
    foreach (L6[i]) p[6] ^= d[L6[i]];
    return p;
  endfunction

  task automatic model_apply();
    bit          of;
    bit          inf;
    logic [36:0] cw;
    of  = (mq.size() != 0) && (bus.out_ready === 1'b1);
    inf = (bus.in_valid === 1'b1) && (mq.size() < 2);
    if (of) begin
      void'(mq.pop_front());
      if (mcnt < 65535) mcnt++;
    end
    if (inf) begin
      cw = {ref_parity(bus.in_data), bus.in_data};
`ifdef ECC_ERR_INJ_EN
      if (bus.inj_en && (int'(bus.inj_idx) <= 36)) begin
        cw[int'(bus.inj_idx)] = ~cw[int'(bus.inj_idx)];
        if (bus.inj_dbit) begin
          cw[(int'(bus.inj_idx) + 1) % 37] =
            ~cw[(int'(bus.inj_idx) + 1) % 37];
        end
      end
`endif
      mq.push_back(cw);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_apply();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_out_valid got %b exp 0", bus.out_valid);
    end
    tests++;
    if (bus.out_data !== 30'd0 || bus.out_parity !== 7'd0) begin
      fails++;
      $display("FAIL rst_out_cw got %h/%h exp 0/0",
               bus.out_parity, bus.out_data);
    end
    tests++;
    if (enc_cnt !== 16'd0) begin
      fails++;
      $display("FAIL rst_enc_cnt got %0d exp 0", enc_cnt);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_in_ready got %b exp 1", bus.in_ready);
    end
    mq.delete();
    mcnt = 0;
  endtask

  task automatic test_vectors();
    logic [29:0] vd [3];
    logic [6:0]  vp [3];
    vd = '{30'h0000_0001, 30'h3FFF_FFFF, 30'h0000_0000};
    vp = '{7'h43, 7'h1B, 7'h00};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vd[i];
      step();
      bus.in_valid = 1'b0;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== vd[i]) begin
        fails++;
        $display("FAIL vec_data[%0d] got v=%b %h exp v=1 %h",
                 i, bus.out_valid, bus.out_data, vd[i]);
      end
      tests++;
      if (bus.out_parity !== vp[i]) begin
        fails++;
        $display("FAIL vec_parity[%0d] got %h exp %h",
                 i, bus.out_parity, vp[i]);
      end
      step();
      tests++;
      if (enc_cnt !== 16'(i + 1) || bus.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL vec_cnt[%0d] got %0d v=%b exp %0d v=0",
                 i, enc_cnt, bus.out_valid, i + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [29:0] a, b, c;
    a = 30'($urandom);
    b = 30'($urandom);
    c = 30'($urandom);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = a;
    step();
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_data !== a) begin
      fails++;
      $display("FAIL bp_first got rdy=%b %h exp rdy=1 %h",
               bus.in_ready, bus.out_data, a);
    end
    bus.in_data = b;
    step();
    bus.in_data = c;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (bus.in_ready !== 1'b0 || bus.out_data !== a ||
          bus.out_parity !== ref_parity(a)) begin
        fails++;
        $display("FAIL bp_stall[%0d] got rdy=%b %h exp rdy=0 %h",
                 i, bus.in_ready, bus.out_data, a);
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    tests++;
    if (bus.out_data !== b || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_order_b got %h rdy=%b exp %h rdy=1",
               bus.out_data, bus.in_ready, b);
    end
    step();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_data !== c || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_order_c got %h v=%b exp %h v=1",
               bus.out_data, bus.out_valid, c);
    end
    step();
    tests++;
    if (bus.out_valid !== 1'b0 || enc_cnt !== 16'(mcnt)) begin
      fails++;
      $display("FAIL bp_drain got v=%b cnt=%0d exp v=0 cnt=%0d",
               bus.out_valid, enc_cnt, mcnt);
    end
  endtask

  task automatic test_streaming();
    int unsigned bad;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    mq.delete();
    mcnt = 0;
    bad  = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus.in_data = 30'($urandom);
      step();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 ||
          {bus.out_parity, bus.out_data} !== mq[0]) begin
        bad++;
        if (bad < 5) begin
          $display("FAIL stream[%0d] got %h exp %h", i,
                   {bus.out_parity, bus.out_data}, mq[0]);
        end
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stream_words got %0d bad exp 0", bad);
    end
    bus.in_valid = 1'b0;
    step();
    tests++;
    if (enc_cnt !== 16'd1000 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_cnt got %0d v=%b exp 1000 v=0",
               enc_cnt, bus.out_valid);
    end
  endtask

  task automatic test_random();
    int unsigned bad;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_data   = 30'($urandom);
      step();
      if (bus.out_valid !== (mq.size() != 0) ||
          bus.in_ready !== (mq.size() < 2) ||
          enc_cnt !== 16'(mcnt) ||
          (mq.size() != 0 &&
           {bus.out_parity, bus.out_data} !== mq[0])) begin
        bad++;
        if (bad < 5) begin
          $display("FAIL rand[%0d] got v=%b r=%b cnt=%0d exp q=%0d cnt=%0d",
                   i, bus.out_valid, bus.in_ready, enc_cnt,
                   mq.size(), mcnt);
        end
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rand_cycles got %0d bad exp 0", bad);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
  endtask

  task automatic test_inject();
    logic [29:0] d;
    logic [36:0] clean;
    int          nflip;
    int          eflip [6];
`ifdef ECC_ERR_INJ_EN
    eflip = '{1, 2, 2, 0, 1, 0};
`else
    eflip = '{0, 0, 0, 0, 0, 0};
`endif
    bus.out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      d = (t < 2) ? 30'd1 : 30'($urandom);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.inj_en   = (t != 5);
      bus.inj_dbit = (t >= 1 && t <= 3);
      case (t)
        0, 1:    bus.inj_idx = 6'd0;
        2:       bus.inj_idx = 6'd36;
        3:       bus.inj_idx = 6'd40;
        default: bus.inj_idx = 6'($urandom_range(0, 36));
      endcase
      step();
      bus.in_valid = 1'b0;
      bus.inj_en   = 1'b0;
      clean = {ref_parity(d), d};
      tests++;
      if ({bus.out_parity, bus.out_data} !== mq[0]) begin
        fails++;
        $display("FAIL inj_cw[%0d] got %h exp %h", t,
                 {bus.out_parity, bus.out_data}, mq[0]);
      end
      nflip = $countones({bus.out_parity, bus.out_data} ^ clean);
      tests++;
      if (nflip != eflip[t]) begin
        fails++;
        $display("FAIL inj_flips[%0d] got %0d exp %0d",
                 t, nflip, eflip[t]);
      end
      step();
    end
    bus.inj_dbit = 1'b0;
    bus.inj_idx  = 6'd0;
  endtask

  task automatic test_saturation();
    int occ4;
    int cnt4;
    occ4 = 0;
    cnt4 = 0;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      bus4.in_valid = (i < 20);
      bus4.in_data  = 30'($urandom);
      @(posedge clk);
      if (occ4 > 0) begin
        occ4--;
        if (cnt4 < 15) cnt4++;
      end
      if (bus4.in_valid && occ4 < 2) occ4++;
      @(negedge clk);
      tests++;
      if (enc_cnt4 !== 4'(cnt4)) begin
        fails++;
        $display("FAIL sat_cnt[%0d] got %0d exp %0d",
                 i, enc_cnt4, cnt4);
      end
    end
    bus4.in_valid = 1'b0;
    tests++;
    if (enc_cnt4 !== 4'hF) begin
      fails++;
      $display("FAIL sat_final got %h exp f", enc_cnt4);
    end
  endtask

  task automatic test_reset_mid();
    logic [29:0] d;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 30'($urandom);
    step();
    bus.in_data   = 30'($urandom);
    step();
    bus.in_valid  = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_full got v=%b r=%b exp v=1 r=0",
               bus.out_valid, bus.in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_async got v=%b r=%b exp v=0 r=1",
               bus.out_valid, bus.in_ready);
    end
    tests++;
    if (bus.out_data !== 30'd0 || enc_cnt !== 16'd0) begin
      fails++;
      $display("FAIL mid_clear got %h cnt=%0d exp 0 cnt=0",
               bus.out_data, enc_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    mcnt = 0;
    d = 30'($urandom);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    step();
    bus.in_valid  = 1'b0;
    tests++;
    if ({bus.out_parity, bus.out_data} !== {ref_parity(d), d}) begin
      fails++;
      $display("FAIL mid_after got %h exp %h",
               {bus.out_parity, bus.out_data}, {ref_parity(d), d});
    end
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    mcnt  = 0;
    rst_n = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus.inj_en     = 1'b0;
    bus.inj_dbit   = 1'b0;
    bus.inj_idx    = '0;
    bus4.in_valid  = 1'b0;
    bus4.in_data   = '0;
    bus4.out_ready = 1'b1;
    bus4.inj_en    = 1'b0;
    bus4.inj_dbit  = 1'b0;
    bus4.inj_idx   = '0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_streaming();
    test_random();
    test_inject();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
